// File: rtl/rd_pkg.sv
// Shared constants and helpers for the register-read / forwarding stage.
// Control-bundle bit positions are opaque here; they only document the decoder layout.
package rd_pkg;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

   localparam int unsigned CTRL_ALUOP_LSB  = 0;
   localparam int unsigned CTRL_ALUOP_MSB  = 3;
   localparam int unsigned CTRL_ALUSRC     = 4;
   localparam int unsigned CTRL_MEMWR      = 5;
   localparam int unsigned CTRL_MEMTOREG   = 6;
   localparam int unsigned CTRL_BRANCH     = 7;
   localparam int unsigned CTRL_JUMP       = 8;

   localparam int unsigned ZERO_REG        = 0;

   localparam int unsigned CTRL_MAXW       = 64;
   localparam logic [CTRL_MAXW-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/rd_fwd_stage_if.sv
// Pipeline-side bus of the decode stage: IF/ID inputs, forwarding sources and ID/EX outputs.
// The master drives the instruction and forwarding inputs; the slave is the stage itself.
interface rd_fwd_stage_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned CTRLW = 16
);
   logic             IF_Valid;
   logic [31:0]      IF_Instr;
   logic [XLEN-1:0]  IF_PCValP4;
   logic [CTRLW-1:0] Dec_Ctrl;
   logic [AW-1:0]    Dec_Rd;
   logic             Dec_RegWr;
   logic             Dec_MemRd;
   logic             Dec_SignExtend;
   logic             Dec_UsesRs;
   logic             Dec_UsesRt;
   logic [AW-1:0]    EXM_Rd;
   logic             EXM_RegWr;
   logic             EXM_MemRd;
   logic [XLEN-1:0]  EXM_Val;
   logic [AW-1:0]    WB_Rd;
   logic             WB_RegWr;
   logic [XLEN-1:0]  WB_RegWVal;
   logic             Flush;

   logic             Stall;
   logic             ID_Valid;
   logic [AW-1:0]    ID_Rs;
   logic [AW-1:0]    ID_Rt;
   logic [AW-1:0]    ID_Rd;
   logic [XLEN-1:0]  ID_RsVal;
   logic [XLEN-1:0]  ID_RtVal;
   logic [XLEN-1:0]  ID_Imm;
   logic [4:0]       ID_Shamt;
   logic [XLEN-1:0]  ID_NewPCVal;
   logic             ID_RsEqRt;
   logic [CTRLW-1:0] ID_Ctrl;
   logic             ID_RegWr;
   logic             ID_MemRd;

   modport master (
      output IF_Valid, IF_Instr, IF_PCValP4, Dec_Ctrl, Dec_Rd, Dec_RegWr, Dec_MemRd,
             Dec_SignExtend, Dec_UsesRs, Dec_UsesRt, EXM_Rd, EXM_RegWr, EXM_MemRd,
             EXM_Val, WB_Rd, WB_RegWr, WB_RegWVal, Flush,
      input  Stall, ID_Valid, ID_Rs, ID_Rt, ID_Rd, ID_RsVal, ID_RtVal, ID_Imm,
             ID_Shamt, ID_NewPCVal, ID_RsEqRt, ID_Ctrl, ID_RegWr, ID_MemRd
   );

   modport slave (
      input  IF_Valid, IF_Instr, IF_PCValP4, Dec_Ctrl, Dec_Rd, Dec_RegWr, Dec_MemRd,
             Dec_SignExtend, Dec_UsesRs, Dec_UsesRt, EXM_Rd, EXM_RegWr, EXM_MemRd,
             EXM_Val, WB_Rd, WB_RegWr, WB_RegWVal, Flush,
      output Stall, ID_Valid, ID_Rs, ID_Rt, ID_Rd, ID_RsVal, ID_RtVal, ID_Imm,
             ID_Shamt, ID_NewPCVal, ID_RsEqRt, ID_Ctrl, ID_RegWr, ID_MemRd
   );
endinterface

// File: rtl/rd_regfile.sv
// General register file: two asynchronous read ports, one synchronous write port.
// Register 0 always reads zero and is never written.
module rd_regfile
   import rd_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   ra0,
   input  logic [AW-1:0]   ra1,
   output logic [XLEN-1:0] rd0,
   output logic [XLEN-1:0] rd1,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd
);
   logic [XLEN-1:0] regs [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && (wa != AW'(ZERO_REG))) begin
         regs[wa] <= wd;
      end
   end

   assign rd0 = (ra0 == AW'(ZERO_REG)) ? '0 : regs[ra0];
   assign rd1 = (ra1 == AW'(ZERO_REG)) ? '0 : regs[ra1];
endmodule

// File: rtl/rd_fwd_stage.sv
// Register-read/decode stage: operand read with EX/MEM and WB forwarding, immediate
// extension, branch target, RAW hazard stall and the ID/EX pipeline register.
module rd_fwd_stage
   import rd_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREG  = 32,
   parameter int unsigned AW    = clog2(NREG),
   parameter int unsigned CTRLW = 16
) (
   input logic           Clk,
   input logic           Rst,
   rd_fwd_stage_if.slave bus
);
   logic [AW-1:0]    rs, rt;
   logic [XLEN-1:0]  rf_rs, rf_rt;
   logic [XLEN-1:0]  rs_val, rt_val, imm, npc;
   logic             haz_rs, haz_rt, stall, load;

   logic             id_valid, id_regwr, id_memrd, id_eq;
   logic [AW-1:0]    id_rs, id_rt, id_rd;
   logic [XLEN-1:0]  id_rsval, id_rtval, id_imm, id_npc;
   logic [4:0]       id_shamt;
   logic [CTRLW-1:0] id_ctrl;

   logic             unused_opcode;

   assign unused_opcode = ^bus.IF_Instr[31:26];

   assign rs = AW'(bus.IF_Instr[25:21]);
   assign rt = AW'(bus.IF_Instr[20:16]);

   rd_regfile #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (AW)
   ) u_rf (
      .clk (Clk),
      .rst (Rst),
      .ra0 (rs),
      .ra1 (rt),
      .rd0 (rf_rs),
      .rd1 (rf_rt),
      .we  (bus.WB_RegWr),
      .wa  (bus.WB_Rd),
      .wd  (bus.WB_RegWVal)
   );

   // A load in EX/MEM has no value yet, so it never forwards; the hazard logic covers it.
   function automatic logic [XLEN-1:0] resolve(input logic [AW-1:0] idx,
                                               input logic [XLEN-1:0] rf_val);
      if (idx == AW'(ZERO_REG))
         return '0;
      else if (bus.EXM_RegWr && !bus.EXM_MemRd && (bus.EXM_Rd == idx))
         return bus.EXM_Val;
      else if (bus.WB_RegWr && (bus.WB_Rd == idx))
         return bus.WB_RegWVal;
      else
         return rf_val;
   endfunction

   function automatic logic pending(input logic [AW-1:0] idx);
      if (idx == AW'(ZERO_REG))
         return 1'b0;
      return (id_valid && id_regwr && (id_rd == idx)) ||
             (bus.EXM_RegWr && bus.EXM_MemRd && (bus.EXM_Rd == idx));
   endfunction

   always_comb begin
      rs_val = resolve(rs, rf_rs);
      rt_val = resolve(rt, rf_rt);
      haz_rs = bus.Dec_UsesRs && pending(rs);
      haz_rt = bus.Dec_UsesRt && pending(rt);
   end

   assign imm   = {{(XLEN-16){bus.Dec_SignExtend & bus.IF_Instr[15]}}, bus.IF_Instr[15:0]};
   assign npc   = bus.IF_PCValP4 + (imm << 2);
   assign stall = bus.IF_Valid && !bus.Flush && (haz_rs || haz_rt);
   assign load  = bus.IF_Valid && !bus.Flush && !stall;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst || !load) begin
         id_valid <= 1'b0;
         id_regwr <= 1'b0;
         id_memrd <= 1'b0;
         id_eq    <= 1'b0;
         id_rs    <= '0;
         id_rt    <= '0;
         id_rd    <= '0;
         id_rsval <= '0;
         id_rtval <= '0;
         id_imm   <= '0;
         id_npc   <= '0;
         id_shamt <= '0;
         id_ctrl  <= CTRL_BUBBLE[CTRLW-1:0];
      end else begin
         id_valid <= 1'b1;
         id_regwr <= bus.Dec_RegWr;
         id_memrd <= bus.Dec_MemRd;
         id_eq    <= (rs_val == rt_val);
         id_rs    <= rs;
         id_rt    <= rt;
         id_rd    <= bus.Dec_Rd;
         id_rsval <= rs_val;
         id_rtval <= rt_val;
         id_imm   <= imm;
         id_npc   <= npc;
         id_shamt <= bus.IF_Instr[10:6];
         id_ctrl  <= bus.Dec_Ctrl;
      end
   end

   assign bus.Stall       = stall;
   assign bus.ID_Valid    = id_valid;
   assign bus.ID_Rs       = id_rs;
   assign bus.ID_Rt       = id_rt;
   assign bus.ID_Rd       = id_rd;
   assign bus.ID_RsVal    = id_rsval;
   assign bus.ID_RtVal    = id_rtval;
   assign bus.ID_Imm      = id_imm;
   assign bus.ID_Shamt    = id_shamt;
   assign bus.ID_NewPCVal = id_npc;
   assign bus.ID_RsEqRt   = id_eq;
   assign bus.ID_Ctrl     = id_ctrl;
   assign bus.ID_RegWr    = id_regwr;
   assign bus.ID_MemRd    = id_memrd;
endmodule

// File: tb/tb_rd_fwd_stage.sv
// Bench for rd_fwd_stage: directed pipeline scenarios plus randomized traffic checked
// against a register-array / pipeline-slot model of the decode stage.
module tb_rd_fwd_stage;
   localparam int unsigned XLEN = 32, NREG = 32, AW = 5, CTRLW = 16;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   always #5 Clk = ~Clk;

   rd_fwd_stage_if #(.XLEN(XLEN), .AW(AW), .CTRLW(CTRLW)) bus ();

   rd_fwd_stage #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .CTRLW(CTRLW)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   int unsigned total = 0, bad = 0;

   logic [31:0] mreg [32];
   logic        e_valid, e_regwr, e_memrd, e_eq;
   logic [4:0]  e_rs, e_rt, e_rd, e_shamt;
   logic [31:0] e_rsval, e_rtval, e_imm, e_npc;
   logic [15:0] e_ctrl;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
      {e_valid, e_regwr, e_memrd, e_eq} = '0;
      {e_rs, e_rt, e_rd, e_shamt} = '0;
      {e_rsval, e_rtval, e_imm, e_npc} = '0;
      e_ctrl = '0;
   endtask

   function automatic logic [31:0] m_operand(input logic [4:0] idx);
      if (idx == 0) return 32'h0;
      if (bus.EXM_RegWr && !bus.EXM_MemRd && bus.EXM_Rd == idx) return bus.EXM_Val;
      if (bus.WB_RegWr && bus.WB_Rd == idx) return bus.WB_RegWVal;
      return mreg[idx];
   endfunction

   function automatic logic m_waiting(input logic [4:0] idx);
      if (idx == 0) return 1'b0;
      if (e_valid && e_regwr && e_rd == idx) return 1'b1;
      return bus.EXM_RegWr && bus.EXM_MemRd && bus.EXM_Rd == idx;
   endfunction

   function automatic logic m_stall();
      logic r;
      r = (bus.Dec_UsesRs && m_waiting(bus.IF_Instr[25:21])) ||
          (bus.Dec_UsesRt && m_waiting(bus.IF_Instr[20:16]));
      return bus.IF_Valid && !bus.Flush && r;
   endfunction

   task automatic idle();
      bus.IF_Valid = 0; bus.IF_Instr = 0; bus.IF_PCValP4 = 0; bus.Dec_Ctrl = 0;
      bus.Dec_Rd = 0; bus.Dec_RegWr = 0; bus.Dec_MemRd = 0; bus.Dec_SignExtend = 0;
      bus.Dec_UsesRs = 0; bus.Dec_UsesRt = 0; bus.EXM_Rd = 0; bus.EXM_RegWr = 0;
      bus.EXM_MemRd = 0; bus.EXM_Val = 0; bus.WB_Rd = 0; bus.WB_RegWr = 0;
      bus.WB_RegWVal = 0; bus.Flush = 0;
   endtask

   task automatic issue(input logic [31:0] instr, input logic [4:0] rd, input logic regwr,
                        input logic use_rs, input logic use_rt);
      bus.IF_Valid = 1; bus.IF_Instr = instr; bus.Dec_Rd = rd; bus.Dec_RegWr = regwr;
      bus.Dec_UsesRs = use_rs; bus.Dec_UsesRt = use_rt; bus.Dec_Ctrl = 16'hA5C3;
   endtask

   // Predict the ID/EX contents from the current inputs, clock once, then commit the model.
   task automatic tick();
      logic        go;
      logic [31:0] imm, a, b;
      logic [4:0]  s, t;
      s   = bus.IF_Instr[25:21];
      t   = bus.IF_Instr[20:16];
      go  = bus.IF_Valid && !bus.Flush && !m_stall();
      imm = bus.Dec_SignExtend ? 32'($signed(bus.IF_Instr[15:0])) : {16'h0, bus.IF_Instr[15:0]};
      a   = m_operand(s);
      b   = m_operand(t);
      @(posedge Clk); #1;
      if (bus.WB_RegWr && bus.WB_Rd != 0) mreg[bus.WB_Rd] = bus.WB_RegWVal;
      if (go) begin
         e_valid = 1; e_regwr = bus.Dec_RegWr; e_memrd = bus.Dec_MemRd; e_eq = (a == b);
         e_rs = s; e_rt = t; e_rd = bus.Dec_Rd; e_shamt = bus.IF_Instr[10:6];
         e_rsval = a; e_rtval = b; e_imm = imm; e_npc = bus.IF_PCValP4 + imm * 4;
         e_ctrl = bus.Dec_Ctrl;
      end else begin
         {e_valid, e_regwr, e_memrd, e_eq} = '0;
         {e_rs, e_rt, e_rd, e_shamt} = '0;
         {e_rsval, e_rtval, e_imm, e_npc} = '0;
         e_ctrl = '0;
      end
   endtask

   task automatic test_reset();
      idle();
      Rst = 1;
      model_reset();
      @(posedge Clk); #1;
      total++;
      if ({bus.ID_Valid, bus.ID_RsVal, bus.ID_Imm, bus.ID_Ctrl, bus.ID_RegWr} !== '0) begin
         bad++;
         $display("FAIL reset_id valid=%b rsval=%h imm=%h ctrl=%h regwr=%b required all 0",
                  bus.ID_Valid, bus.ID_RsVal, bus.ID_Imm, bus.ID_Ctrl, bus.ID_RegWr);
      end
      Rst = 0;
      @(posedge Clk); #1;
   endtask

   task automatic test_addi();
      issue(32'h2001_FFFC, 5'd1, 1'b1, 1'b1, 1'b0);
      bus.IF_PCValP4 = 32'h100; bus.Dec_SignExtend = 1;
      tick();
      total++;
      if ({bus.ID_Valid, bus.ID_Imm, bus.ID_NewPCVal, bus.ID_RsVal} !==
          {1'b1, 32'hFFFF_FFFC, 32'h0000_00F0, 32'h0}) begin
         bad++;
         $display("FAIL addi valid=%b imm=%h npc=%h rsval=%h required 1 fffffffc 000000f0 0",
                  bus.ID_Valid, bus.ID_Imm, bus.ID_NewPCVal, bus.ID_RsVal);
      end
      idle(); tick();
   endtask

   task automatic test_wb_bypass();
      issue(32'h00A0_0000, 5'd0, 1'b0, 1'b1, 1'b0);
      bus.WB_RegWr = 1; bus.WB_Rd = 5; bus.WB_RegWVal = 32'hDEAD;
      tick();
      total++;
      if (bus.ID_RsVal !== 32'hDEAD) begin
         bad++; $display("FAIL wb_bypass got=%h required=0000dead", bus.ID_RsVal);
      end
      idle();
      issue(32'h00A0_0000, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
      total++;
      if (bus.ID_RsVal !== 32'hDEAD) begin
         bad++; $display("FAIL rf_holds_r5 got=%h required=0000dead", bus.ID_RsVal);
      end
      idle(); tick();
   endtask

   task automatic test_alu_fwd();
      issue(32'h0000_0000, 5'd3, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      issue(32'h0060_0000, 5'd0, 1'b0, 1'b1, 1'b0);
      #1;
      total++;
      if (bus.Stall !== 1'b1) begin
         bad++; $display("FAIL alu_stall got=%b required=1", bus.Stall);
      end
      tick();
      total++;
      if ({bus.ID_Valid, bus.ID_RegWr, bus.ID_Ctrl} !== '0) begin
         bad++; $display("FAIL alu_bubble valid=%b regwr=%b ctrl=%h required 0",
                         bus.ID_Valid, bus.ID_RegWr, bus.ID_Ctrl);
      end
      bus.EXM_RegWr = 1; bus.EXM_Rd = 3; bus.EXM_Val = 32'h7;
      #1;
      total++;
      if (bus.Stall !== 1'b0) begin
         bad++; $display("FAIL alu_unstall got=%b required=0", bus.Stall);
      end
      tick();
      total++;
      if ({bus.ID_Valid, bus.ID_RsVal} !== {1'b1, 32'h7}) begin
         bad++; $display("FAIL alu_exm_fwd valid=%b rsval=%h required 1 00000007",
                         bus.ID_Valid, bus.ID_RsVal);
      end
      idle(); tick();
   endtask

   task automatic test_load_use();
      issue(32'h0004_0000, 5'd0, 1'b0, 1'b0, 1'b1);
      bus.EXM_RegWr = 1; bus.EXM_MemRd = 1; bus.EXM_Rd = 4; bus.EXM_Val = 32'h1234;
      #1;
      total++;
      if (bus.Stall !== 1'b1) begin
         bad++; $display("FAIL load_stall got=%b required=1", bus.Stall);
      end
      tick();
      bus.EXM_RegWr = 0; bus.EXM_MemRd = 0; bus.EXM_Rd = 0;
      bus.WB_RegWr = 1; bus.WB_Rd = 4; bus.WB_RegWVal = 32'h9;
      #1;
      total++;
      if (bus.Stall !== 1'b0) begin
         bad++; $display("FAIL load_unstall got=%b required=0", bus.Stall);
      end
      tick();
      total++;
      if ({bus.ID_Valid, bus.ID_RtVal} !== {1'b1, 32'h9}) begin
         bad++; $display("FAIL load_wb_fwd valid=%b rtval=%h required 1 00000009",
                         bus.ID_Valid, bus.ID_RtVal);
      end
      idle(); tick();
   endtask

   task automatic test_flush();
      issue(32'h0000_0000, 5'd3, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      issue(32'h0060_0000, 5'd6, 1'b1, 1'b1, 1'b0);
      bus.Flush = 1;
      #1;
      total++;
      if (bus.Stall !== 1'b0) begin
         bad++; $display("FAIL flush_stall got=%b required=0", bus.Stall);
      end
      tick();
      total++;
      if ({bus.ID_Valid, bus.ID_RegWr, bus.ID_Ctrl} !== '0) begin
         bad++; $display("FAIL flush_bubble valid=%b regwr=%b ctrl=%h required 0",
                         bus.ID_Valid, bus.ID_RegWr, bus.ID_Ctrl);
      end
      idle(); tick();
   endtask

   task automatic test_r0();
      issue(32'h0000_0000, 5'd0, 1'b1, 1'b1, 1'b1);
      bus.WB_RegWr = 1; bus.WB_Rd = 0; bus.WB_RegWVal = 32'h55;
      bus.EXM_RegWr = 1; bus.EXM_Rd = 0; bus.EXM_MemRd = 1; bus.EXM_Val = 32'h77;
      #1;
      total++;
      if (bus.Stall !== 1'b0) begin
         bad++; $display("FAIL r0_stall got=%b required=0", bus.Stall);
      end
      tick();
      total++;
      if ({bus.ID_RsEqRt, bus.ID_RsVal, bus.ID_RtVal} !== {1'b1, 64'h0}) begin
         bad++; $display("FAIL r0_read eq=%b rs=%h rt=%h required 1 0 0",
                         bus.ID_RsEqRt, bus.ID_RsVal, bus.ID_RtVal);
      end
      idle(); tick();
   endtask

   task automatic test_reset_midstream();
      issue(32'h2001_1234, 5'd2, 1'b1, 1'b0, 1'b0);
      bus.IF_PCValP4 = 32'h40;
      tick();
      #2 Rst = 1;
      #1;
      model_reset();
      total++;
      if ({bus.ID_Valid, bus.ID_Imm, bus.ID_NewPCVal, bus.ID_Ctrl, bus.ID_RegWr} !== '0) begin
         bad++; $display("FAIL async_reset valid=%b imm=%h npc=%h ctrl=%h regwr=%b required 0",
                         bus.ID_Valid, bus.ID_Imm, bus.ID_NewPCVal, bus.ID_Ctrl, bus.ID_RegWr);
      end
      idle();
      @(posedge Clk); #1 Rst = 0;
      issue(32'h00A0_0000, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
      total++;
      if (bus.ID_RsVal !== 32'h0) begin
         bad++; $display("FAIL reset_clears_rf got=%h required=00000000", bus.ID_RsVal);
      end
      idle(); tick();
   endtask

   task automatic test_random();
      logic [31:0] instr;
      for (int c = 0; c < 400; c++) begin
         instr = $urandom;
         instr[25:21] = 5'($urandom_range(0, 7));
         instr[20:16] = 5'($urandom_range(0, 7));
         bus.IF_Valid = ($urandom_range(0, 9) < 8); bus.IF_Instr = instr;
         bus.IF_PCValP4 = $urandom; bus.Dec_Ctrl = 16'($urandom);
         bus.Dec_Rd = 5'($urandom_range(0, 7)); bus.Dec_RegWr = 1'($urandom);
         bus.Dec_MemRd = ($urandom_range(0, 3) == 0); bus.Dec_SignExtend = 1'($urandom);
         bus.Dec_UsesRs = 1'($urandom); bus.Dec_UsesRt = 1'($urandom);
         bus.EXM_Rd = 5'($urandom_range(0, 7)); bus.EXM_RegWr = 1'($urandom);
         bus.EXM_MemRd = ($urandom_range(0, 3) == 0); bus.EXM_Val = $urandom;
         bus.WB_Rd = 5'($urandom_range(0, 7)); bus.WB_RegWr = 1'($urandom);
         bus.WB_RegWVal = $urandom; bus.Flush = ($urandom_range(0, 9) == 0);
         #1;
         total++;
         if (bus.Stall !== m_stall()) begin
            bad++; $display("FAIL rand_stall cyc=%0d got=%b required=%b", c, bus.Stall, m_stall());
         end
         tick();
         total++;
         if ({bus.ID_Valid, bus.ID_RegWr, bus.ID_MemRd, bus.ID_Ctrl} !==
             {e_valid, e_regwr, e_memrd, e_ctrl}) begin
            bad++; $display("FAIL rand_ctl cyc=%0d got=%b%b%b/%h required=%b%b%b/%h", c,
                            bus.ID_Valid, bus.ID_RegWr, bus.ID_MemRd, bus.ID_Ctrl,
                            e_valid, e_regwr, e_memrd, e_ctrl);
         end
         total++;
         if ({bus.ID_RsVal, bus.ID_RtVal, bus.ID_RsEqRt} !== {e_rsval, e_rtval, e_eq}) begin
            bad++; $display("FAIL rand_operands cyc=%0d got=%h/%h/%b required=%h/%h/%b", c,
                            bus.ID_RsVal, bus.ID_RtVal, bus.ID_RsEqRt, e_rsval, e_rtval, e_eq);
         end
         total++;
         if ({bus.ID_Imm, bus.ID_NewPCVal} !== {e_imm, e_npc}) begin
            bad++; $display("FAIL rand_imm_npc cyc=%0d got=%h/%h required=%h/%h", c,
                            bus.ID_Imm, bus.ID_NewPCVal, e_imm, e_npc);
         end
         total++;
         if ({bus.ID_Rs, bus.ID_Rt, bus.ID_Rd, bus.ID_Shamt} !== {e_rs, e_rt, e_rd, e_shamt}) begin
            bad++; $display("FAIL rand_fields cyc=%0d got=%h/%h/%h/%h required=%h/%h/%h/%h", c,
                            bus.ID_Rs, bus.ID_Rt, bus.ID_Rd, bus.ID_Shamt,
                            e_rs, e_rt, e_rd, e_shamt);
         end
      end
      idle(); tick();
   endtask

   initial begin
      idle();
      test_reset();
      test_addi();
      test_wb_bypass();
      test_alu_fwd();
      test_load_use();
      test_flush();
      test_r0();
      test_reset_midstream();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rd_fwd_stage.md
Name: rd_fwd_stage

Overview:
- Parametrised register-read/decode stage for the five-stage MIPS pipeline.
- Owns the general register file and performs operand read, forwarding from EX/MEM and WB, and sign/zero immediate extension.
- Computes the branch target and detects read-after-write hazards, then registers everything into the ID/EX pipeline register.
- Generalises the fixed 32×32 decode stage with configurable width and depth, forwarding, stall/flush and an early Rs==Rt compare.

Parameters:
- XLEN, 32, datapath/register width (≥32).
- NREG, 32, number of architectural registers (power of two); register 0 is hardwired to zero.
- AW, 5, register index width = log2(NREG).
- CTRLW, 16, width of opaque decoder control bundle passed through to EX.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset; one clock, asynchronous, active-high.
- IF_Valid  in  1  IF/ID holds a real instruction.
- IF_Instr  in  32  instruction word.
- IF_PCValP4  in  XLEN  PC+4 of instruction.
- Dec_Ctrl  in  CTRLW  decoder control bundle for IF_Instr.
- Dec_Rd  in  AW  destination index chosen by decoder.
- Dec_RegWr  in  1  instruction writes Dec_Rd.
- Dec_MemRd  in  1  instruction is a load.
- Dec_SignExtend  in  1  sign-extend imm16, else zero-extend.
- Dec_UsesRs  in  1  instruction reads Rs.
- Dec_UsesRt  in  1  instruction reads Rt.
- EXM_Rd  in  AW  destination of EX/MEM register.
- EXM_RegWr  in  1  EX/MEM writes a register.
- EXM_MemRd  in  1  EX/MEM holds a load (value not ready).
- EXM_Val  in  XLEN  ALU result in EX/MEM.
- WB_Rd  in  AW  write-back destination.
- WB_RegWr  in  1  write-back enable.
- WB_RegWVal  in  XLEN  write-back data.
- Flush  in  1  kill instruction in IF/ID (taken branch/jump).
- Stall  out  1  hold PC and IF/ID this cycle.
- ID_Valid  out  1  ID/EX holds a real instruction.
- ID_Rs, ID_Rt, ID_Rd  out  AW each  registered indices.
- ID_RsVal, ID_RtVal  out  XLEN each  registered resolved operands.
- ID_Imm  out  XLEN  registered extended immediate.
- ID_Shamt  out  5  IF_Instr[10:6] registered.
- ID_NewPCVal  out  XLEN  registered IF_PCValP4 + (Imm<<2).
- ID_RsEqRt  out  1  registered (RsVal == RtVal).
- ID_Ctrl  out  CTRLW  registered control bundle.
- ID_RegWr, ID_MemRd  out  1 each  registered, gated by ID_Valid.

Behaviour:
- Indices: Rs = IF_Instr[25:21] and Rt = [20:16], truncated or zero-extended to AW.
- Immediate: upper XLEN-16 bits = Dec_SignExtend & Instr[15]. Branch target addition wraps mod 2^XLEN.
- Operand resolution, per source, in priority order:
  1. Index 0 → 0.
  2. EXM_RegWr && EXM_Rd == idx && !EXM_MemRd → EXM_Val.
  3. WB_RegWr && WB_Rd == idx → WB_RegWVal (same-cycle write-first bypass).
  4. Otherwise the register file.
- Hazard: Stall = IF_Valid & !Flush & (H_rs | H_rt), where for each used nonzero source:
  - H = (ID_Valid & ID_RegWr & ID_Rd == idx), or
  - H = (EXM_RegWr & EXM_MemRd & EXM_Rd == idx).
  - Stall is combinational.
- ID/EX update each rising edge:
  - Flush or Stall or !IF_Valid → bubble: ID_Valid, ID_RegWr, ID_MemRd and ID_Ctrl are 0; other fields don't-care, implemented as 0.
  - Otherwise, load all fields with ID_Valid = 1.
- Flush has priority over Stall. Latency is 1 cycle from IF to ID_*.
- Register file: written on the rising edge when WB_RegWr && WB_Rd != 0. Writes continue during Stall and Flush.
- Reset (async, any time): all registers 0, all ID_* outputs 0, Stall follows its inputs. In-flight data is lost and no partial write occurs.
- Simultaneous hazard on both Rs and Rt produces a single stall cycle per resolving stage.
- A back-to-back dependent ALU op stalls 1 cycle, then forwards from EXM.
- Load-use stalls 2 cycles, then uses the WB bypass.

Decomposition:
- Package rd_pkg holds:
  - the clog2 function;
  - Dec_Ctrl bit-index constants;
  - the ZERO_REG constant;
  - a bubble constant for ID_Ctrl.
- One sub-module, rd_regfile: NREG×XLEN, 2 async read ports, 1 sync write port, async reset clear, r0 forced 0. The write-first bypass lives in rd_fwd_stage.

Test Plan:
- Reset, then a single instruction 0x2001_FFFC (addi r1,r0,-4), PCValP4 = 0x100, sign ext → next cycle:
  - ID_Valid = 1, ID_Imm = 0xFFFFFFFC, ID_NewPCVal = 0xF0, ID_RsVal = 0.
- WB write r5 = 0xDEAD with IF reading r5 the same cycle → ID_RsVal = 0xDEAD; the regfile also holds it afterward.
- ID/EX holds a write to r3, IF reads r3 → Stall = 1 for one cycle and a bubble enters ID/EX. Then, with EXM_Rd = 3, EXM_Val = 7 → ID_RsVal = 7.
- EXM load to r4, IF uses r4 as Rt → Stall = 1. Next cycle WB_Rd = 4, WB_RegWVal = 9 → ID_RtVal = 9, Stall = 0.
- Flush asserted with a hazard present → Stall = 0, bubble loaded, ID_RegWr = 0.
- Reads of r0 while WB writes r0 = 0x55 and EXM_Rd = 0 → no stall, ID_RsEqRt = 1 with both operands 0. Assert Rst mid-stream → all ID_* go to 0 immediately.
